tmds_period_scheduler: RTL and testbench
========================================

// Module: tmds_period_scheduler
// PURPOSE
//  Per-pixel-clock symbol scheduler in front of the three TMDS data-lane serializers and the clock lane.
//  Takes TMDS-encoded video symbols plus raw DE/HSYNC/VSYNC.
//  Outputs the 10-bit symbol each serializer's i_data loads each pixel clock:
//    control symbols, 8-symbol video preamble, 2-symbol video guard band, or video.
//  Delays the stream by a fixed lookahead so the preamble and guard can be inserted ahead of DE.
// PARAMETERS
//  p_preamble_len  8   preamble symbols before each guard band (HDMI fixed value)
//  p_guard_len     2   video guard-band symbols before first active pixel
//  p_min_ctrl      12  min input DE-low gap (pixel clocks) needed to insert preamble+guard; must be >= p_preamble_len+p_guard_len
//  p_dvi_mode      0   1: never insert preamble/guard (pure DVI); o_err_* held 0
// PORTS
//  i_clk           in   1   pixel clock (serializer i_clk_data domain)
//  i_rst_n         in   1   async reset, active low
//  i_de            in   1   active video
//  i_hsync         in   1   horizontal sync
//  i_vsync         in   1   vertical sync
//  i_sym           in   3x10  TMDS-encoded video symbols, [0]=blue [1]=green [2]=red; valid when i_de
//  i_err_clr       in   1   clears o_err_sticky
//  o_sym           out  3x10  symbols to data-lane serializers
//  o_sym_clk       out  10  clock-lane pattern, constant 10'b00000_11111
//  o_de            out  1   delayed DE aligned with o_sym
//  o_err_short     out  1   1-cycle pulse: DE rise with gap < p_min_ctrl; burst skipped
//  o_err_sticky    out  1   set by o_err_short, cleared by i_err_clr (set wins if same cycle)
// BEHAVIOUR
//  Lookahead L = p_preamble_len + p_guard_len.
//    Inputs pass through an L-deep delay line, then one output register stage.
//    Total latency L+1: the input at cycle t appears on the outputs at t+L+1.
//  Control codes (index {c1,c0}): 00=1101010100, 01=0010101011, 10=0101010100, 11=1010101011.
//  Lane control mapping: lane0 = {vsync,hsync} (delayed); lane1 = {CTL1,CTL0}; lane2 = {CTL3,CTL2}; all CTLn = 0 outside preamble.
//  Preamble: CTL0=1, others 0, so lane1 = code 01 and lane2 = code 00; lane0 still carries the sync code.
//  Guard band: lane0 = 1011001100, lane1 = 0100110011, lane2 = 1011001100.
//  Gap counter: counts consecutive input cycles with i_de=0, saturating at p_min_ctrl.
//    Reset value is p_min_ctrl, so the first line is legal.
//    Clears to 0 on any cycle with i_de=1.
//  FSM states: CTRL, PREAMBLE, GUARD, VIDEO. Down-counter cnt sized for L.
//    CTRL -> PREAMBLE, cnt=p_preamble_len-1: on input DE rise (i_de=1, prev 0) with gap >= p_min_ctrl and p_dvi_mode=0.
//    PREAMBLE -> GUARD, cnt=p_guard_len-1: when cnt==0.
//    GUARD -> VIDEO: when cnt==0.
//    VIDEO -> CTRL: when delayed de==0.
//    CTRL, delayed de==1 (skipped burst or DVI mode): output video symbols, state stays CTRL.
//  Short-gap rise (gap < p_min_ctrl, p_dvi_mode=0): no burst inserted; o_err_short pulses in the cycle after the rise.
//  A DE rise while in PREAMBLE/GUARD is unreachable given p_min_ctrl >= L; elaboration-time assertion enforces this.
//  Output mux priority: PREAMBLE > GUARD > delayed de ? video : control.
//  Reset (async assert, sync deassert is upstream's job), all outputs immediately:
//    o_sym = 3x control code 00; o_de = 0; o_err_* = 0; FSM = CTRL; delay line = {de=0, syncs=0}.
//    Assertion mid-line aborts any burst; the first DE rise after release follows normal rules.
//  o_sym_clk is constant, including during reset.
// STRUCTURE
//  Package hdmi_pkg: 10-bit control codes (4), guard-band codes (3), clock pattern, tmds_period_e state enum, lane symbol typedef logic [9:0].
//  Sub-module pipe_delay #(p_depth,p_width): generic shift-register delay line.
//    Instantiated once with width 3*10+3 for {sym,de,hsync,vsync}.
//  FSM, gap counter and output mux live in this module.
// TESTING
//  Reset release, idle (i_de=0, hsync=1, vsync=0) -> o_sym[0]=0010101011, lanes1/2=1101010100, o_de=0, o_sym_clk=0000011111.
//  Line with 20-cycle gap, DE rise at input cycle T:
//    outputs T+1..T+8 show preamble (lane1=0010101011);
//    T+9..T+10 show guard bands;
//    T+11 shows first i_sym with o_de=1.
//  Back-to-back line with 5-cycle DE-low gap -> no preamble/guard, o_err_short=1 for one cycle, o_err_sticky=1;
//    i_err_clr then clears o_err_sticky.
//  p_dvi_mode=1, same 20-cycle-gap line -> control then video directly at T+11, o_err_* never set.
//  i_rst_n pulled low during PREAMBLE -> outputs go to reset values the same cycle, no clock needed;
//    a subsequent legal line after release is framed correctly.
//  Gap of exactly p_min_ctrl=12 accepted (burst inserted); gap of 11 rejected (o_err_short pulse).

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared TMDS period constants: control/guard-band codes, clock-lane pattern and period states.
package hdmi_pkg;

    typedef logic [9:0] tmds_sym_t;

    localparam tmds_sym_t CtrlCode00 = 10'b1101010100;
    localparam tmds_sym_t CtrlCode01 = 10'b0010101011;
    localparam tmds_sym_t CtrlCode10 = 10'b0101010100;
    localparam tmds_sym_t CtrlCode11 = 10'b1010101011;

    localparam tmds_sym_t GuardLane0 = 10'b1011001100;
    localparam tmds_sym_t GuardLane1 = 10'b0100110011;
    localparam tmds_sym_t GuardLane2 = 10'b1011001100;

    localparam tmds_sym_t ClkPattern = 10'b0000011111;

    typedef enum logic [1:0] {
        StCtrl     = 2'd0,
        StPreamble = 2'd1,
        StGuard    = 2'd2,
        StVideo    = 2'd3
    } tmds_period_e;

    // Index is {c1, c0}; for lane 0 that is {vsync, hsync}.
    function automatic tmds_sym_t ctrl_code(input logic [1:0] ctl);
        tmds_sym_t code;
        code = CtrlCode00;
        unique case (ctl)
            2'b00: code = CtrlCode00;
            2'b01: code = CtrlCode01;
            2'b10: code = CtrlCode10;
            2'b11: code = CtrlCode11;
            default: code = CtrlCode00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Generic fixed-depth shift-register delay line; every stage clears on reset.
module pipe_delay #(
    parameter int unsigned p_depth = 1,
    parameter int unsigned p_width = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [p_width-1:0] d_i,
    output logic [p_width-1:0] q_o
);

    logic [p_width-1:0] stage_q [p_depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < p_depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < p_depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[p_depth-1];

endmodule

// File: rtl/tmds_period_scheduler.sv
// Per-pixel-clock TMDS symbol scheduler: delays the stream by a fixed lookahead so the
// video preamble and guard band can be placed ahead of each active line.
module tmds_period_scheduler
    import hdmi_pkg::*;
#(
    parameter int unsigned p_preamble_len = 8,
    parameter int unsigned p_guard_len    = 2,
    parameter int unsigned p_min_ctrl     = 12,
    parameter bit          p_dvi_mode     = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_de,
    input  logic            i_hsync,
    input  logic            i_vsync,
    input  tmds_sym_t [2:0] i_sym,
    input  logic            i_err_clr,
    output tmds_sym_t [2:0] o_sym,
    output tmds_sym_t       o_sym_clk,
    output logic            o_de,
    output logic            o_err_short,
    output logic            o_err_sticky
);

    localparam int unsigned Lookahead = p_preamble_len + p_guard_len;
    localparam int unsigned CntW      = $clog2(Lookahead + 1);
    localparam int unsigned GapW      = $clog2(p_min_ctrl + 1);
    localparam int unsigned PipeW     = 3 * 10 + 3;

    localparam logic [CntW-1:0] PreambleCnt = CntW'(p_preamble_len - 1);
    localparam logic [CntW-1:0] GuardCnt    = CntW'(p_guard_len - 1);
    localparam logic [GapW-1:0] GapSat      = GapW'(p_min_ctrl);

    // A legal DE rise must never land while a burst is still being emitted.
    if (p_min_ctrl < Lookahead) begin : g_bad_min_ctrl
        $error("p_min_ctrl must be >= p_preamble_len + p_guard_len");
    end
    if (p_preamble_len == 0 || p_guard_len == 0) begin : g_bad_len
        $error("p_preamble_len and p_guard_len must be non-zero");
    end

    logic [PipeW-1:0] pipe_in;
    logic [PipeW-1:0] pipe_out;
    tmds_sym_t [2:0]  dly_sym;
    logic             dly_de;
    logic             dly_hsync;
    logic             dly_vsync;

    assign pipe_in = {i_sym, i_de, i_hsync, i_vsync};

    pipe_delay #(
        .p_depth (Lookahead),
        .p_width (PipeW)
    ) u_pipe_delay (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .d_i    (pipe_in),
        .q_o    (pipe_out)
    );

    assign dly_sym   = pipe_out[PipeW-1:3];
    assign dly_de    = pipe_out[2];
    assign dly_hsync = pipe_out[1];
    assign dly_vsync = pipe_out[0];

    // Input-side rise detection and DE-low gap measurement.
    logic            de_prev_q;
    logic [GapW-1:0] gap_q;
    logic [GapW-1:0] gap_d;
    logic            de_rise;
    logic            gap_ok;
    logic            burst_start;
    logic            err_short_d;
    logic            err_short_q;
    logic            err_sticky_d;
    logic            err_sticky_q;

    always_comb begin
        de_rise     = i_de & ~de_prev_q;
        gap_ok      = (gap_q >= GapSat);
        burst_start = de_rise & gap_ok & ~p_dvi_mode;
        err_short_d = de_rise & ~gap_ok & ~p_dvi_mode;

        gap_d = gap_q;
        if (i_de) begin
            gap_d = '0;
        end else if (gap_q != GapSat) begin
            gap_d = gap_q + GapW'(1);
        end

        // A new error in the same cycle as a clear keeps the flag set.
        err_sticky_d = err_short_d | (err_sticky_q & ~i_err_clr);
    end

    tmds_period_e    state_q;
    tmds_period_e    state_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StCtrl: begin
                if (burst_start) begin
                    state_d = StPreamble;
                    cnt_d   = PreambleCnt;
                end
            end
            StPreamble: begin
                if (cnt_q == '0) begin
                    state_d = StGuard;
                    cnt_d   = GuardCnt;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StGuard: begin
                if (cnt_q == '0) begin
                    state_d = StVideo;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StVideo: begin
                // When p_min_ctrl == Lookahead the next rise can coincide with the line end.
                if (!dly_de) begin
                    if (burst_start) begin
                        state_d = StPreamble;
                        cnt_d   = PreambleCnt;
                    end else begin
                        state_d = StCtrl;
                    end
                end
            end
            default: begin
                state_d = StCtrl;
                cnt_d   = '0;
            end
        endcase
    end

    // The output register loads what the period state will be in the cycle it is shown.
    tmds_sym_t [2:0] sym_d;
    tmds_sym_t [2:0] sym_q;
    logic            de_d;
    logic            de_q;

    always_comb begin
        sym_d[0] = ctrl_code({dly_vsync, dly_hsync});
        sym_d[1] = CtrlCode00;
        sym_d[2] = CtrlCode00;
        de_d     = 1'b0;
        if (state_d == StPreamble) begin
            sym_d[1] = CtrlCode01;
        end else if (state_d == StGuard) begin
            sym_d[0] = GuardLane0;
            sym_d[1] = GuardLane1;
            sym_d[2] = GuardLane2;
        end else if (dly_de) begin
            sym_d = dly_sym;
            de_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StCtrl;
            cnt_q        <= '0;
            gap_q        <= GapSat;
            de_prev_q    <= 1'b0;
            sym_q        <= {CtrlCode00, CtrlCode00, CtrlCode00};
            de_q         <= 1'b0;
            err_short_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            de_prev_q    <= i_de;
            sym_q        <= sym_d;
            de_q         <= de_d;
            err_short_q  <= err_short_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign o_sym        = sym_q;
    assign o_sym_clk    = ClkPattern;
    assign o_de         = de_q;
    assign o_err_short  = err_short_q;
    assign o_err_sticky = err_sticky_q;

endmodule

// File: tb/tb_tmds_period_scheduler.sv
// Self-checking bench: an HDMI-mode and a DVI-mode scheduler share one stimulus stream and are
// compared against a history-based model of the period-insertion rules.
module tb_tmds_period_scheduler;

    localparam int L      = 10;
    localparam int MinGap = 12;
    localparam int HMax   = 8192;

    localparam logic [9:0] C00  = 10'b1101010100;
    localparam logic [9:0] C01  = 10'b0010101011;
    localparam logic [9:0] C10  = 10'b0101010100;
    localparam logic [9:0] C11  = 10'b1010101011;
    localparam logic [9:0] G0   = 10'b1011001100;
    localparam logic [9:0] G1   = 10'b0100110011;
    localparam logic [9:0] G2   = 10'b1011001100;
    localparam logic [9:0] ClkP = 10'b0000011111;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        de    = 1'b0;
    logic        hs    = 1'b0;
    logic        vs    = 1'b0;
    logic        clr   = 1'b0;
    logic [29:0] sym   = '0;

    logic [29:0] osym_h, osym_d;
    logic [9:0]  clk_h, clk_d;
    logic        ode_h, ode_d, es_h, es_d, ek_h, ek_d;

    always #5 clk = ~clk;

    tmds_period_scheduler #(.p_dvi_mode(1'b0)) u_hdmi (
        .i_clk(clk), .i_rst_n(rst_n), .i_de(de), .i_hsync(hs), .i_vsync(vs), .i_sym(sym),
        .i_err_clr(clr), .o_sym(osym_h), .o_sym_clk(clk_h), .o_de(ode_h),
        .o_err_short(es_h), .o_err_sticky(ek_h)
    );

    tmds_period_scheduler #(.p_dvi_mode(1'b1)) u_dvi (
        .i_clk(clk), .i_rst_n(rst_n), .i_de(de), .i_hsync(hs), .i_vsync(vs), .i_sym(sym),
        .i_err_clr(clr), .o_sym(osym_d), .o_sym_clk(clk_d), .o_de(ode_d),
        .o_err_short(es_d), .o_err_sticky(ek_d)
    );

    // Input history since the last reset release; index = input cycle.
    bit          de_hist   [HMax];
    bit [1:0]    sync_hist [HMax];
    logic [29:0] sym_hist  [HMax];
    int          n = 0;
    bit          sticky_m = 1'b0;
    int          total = 0;
    int          bad = 0;

    function automatic logic [9:0] ctrl(input bit [1:0] s);
        case (s)
            2'd0: return C00;
            2'd1: return C01;
            2'd2: return C10;
            default: return C11;
        endcase
    endfunction

    function automatic bit is_rise(input int i);
        if (i < 0) return 1'b0;
        return de_hist[i] && (i == 0 || !de_hist[i-1]);
    endfunction

    // Consecutive DE-low cycles before input i; cycles before reset count as saturated.
    function automatic int gap_before(input int i);
        int c = 0;
        bit stop = 1'b0;
        for (int j = i - 1; j >= 0 && j >= i - MinGap; j--) begin
            if (!stop) begin
                if (de_hist[j]) stop = 1'b1;
                else c++;
            end
        end
        if (!stop) return MinGap;
        return c;
    endfunction

    function automatic bit legal_rise(input int i);
        return is_rise(i) && gap_before(i) >= MinGap;
    endfunction

    function automatic bit short_rise(input int i);
        return is_rise(i) && gap_before(i) < MinGap;
    endfunction

    // Expected registered outputs in output cycle k.
    function automatic void model(input int k, input bit dvi, output logic [29:0] esym,
                                  output bit ede, output bit esh);
        int src = k - L - 1;
        bit sde = 1'b0;
        bit [1:0] ssync = 2'b00;
        logic [29:0] ssym = '0;
        bit pre = 1'b0;
        bit grd = 1'b0;
        if (src >= 0) begin
            sde   = de_hist[src];
            ssync = sync_hist[src];
            ssym  = sym_hist[src];
        end
        if (!dvi) begin
            for (int d = 1; d <= 10; d++) begin
                if (legal_rise(k - d)) begin
                    if (d <= 8) pre = 1'b1;
                    else grd = 1'b1;
                end
            end
        end
        if (pre) esym = {C00, C01, ctrl(ssync)};
        else if (grd) esym = {G2, G1, G0};
        else if (sde) esym = ssym;
        else esym = {C00, C00, ctrl(ssync)};
        ede = sde && !pre && !grd;
        esh = !dvi && short_rise(k - 1);
    endfunction

    task automatic drive(input bit d, input bit h, input bit v, input logic [29:0] s,
                         input bit c);
        de = d; hs = h; vs = v; sym = s; clr = c;
        de_hist[n] = d; sync_hist[n] = {v, h}; sym_hist[n] = s;
        @(posedge clk);
        #1;
        sticky_m = short_rise(n) | (sticky_m & ~c);
        n++;
    endtask

    task automatic release_reset();
        n = 0;
        sticky_m = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total += 4;
            if (osym_h !== {C00, C00, C00}) begin
                bad++; $display("FAIL reset_sym got=%h exp=%h", osym_h, {C00, C00, C00});
            end
            if ({ode_h, es_h, ek_h, ode_d, es_d, ek_d} !== 6'b0) begin
                bad++; $display("FAIL reset_flags got=%b exp=000000",
                                {ode_h, es_h, ek_h, ode_d, es_d, ek_d});
            end
            if (clk_h !== ClkP || clk_d !== ClkP) begin
                bad++; $display("FAIL reset_clk got=%b/%b exp=%b", clk_h, clk_d, ClkP);
            end
            if (osym_d !== {C00, C00, C00}) begin
                bad++; $display("FAIL reset_sym_dvi got=%h exp=%h", osym_d, {C00, C00, C00});
            end
            @(posedge clk);
        end
        #1 release_reset();
    endtask

    task automatic test_idle();
        logic [29:0] es; bit ed, esh;
        for (int c = 0; c < 15; c++) begin
            drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
            model(n, 1'b0, es, ed, esh);
            total++;
            if ({osym_h, ode_h, es_h, ek_h} !== {es, ed, esh, sticky_m}) begin
                bad++; $display("FAIL idle_model n=%0d got=%h_%b%b%b exp=%h_%b%b%b",
                                n, osym_h, ode_h, es_h, ek_h, es, ed, esh, sticky_m);
            end
        end
        total += 3;
        if (osym_h !== {C00, C00, C01}) begin
            bad++; $display("FAIL idle_sym got=%h exp=%h", osym_h, {C00, C00, C01});
        end
        if (ode_h !== 1'b0) begin
            bad++; $display("FAIL idle_de got=%b exp=0", ode_h);
        end
        if (clk_h !== ClkP) begin
            bad++; $display("FAIL idle_clk got=%b exp=%b", clk_h, ClkP);
        end
    endtask

    task automatic test_legal_line();
        logic [29:0] es, esd; bit ed, esh, edd, eshd;
        int t = 0;
        int k;
        for (int c = 0; c < 50; c++) begin
            if (c == 20) t = n;
            drive(c >= 20 && c < 36, 1'b1, 1'b0, 30'($urandom), 1'b0);
            model(n, 1'b0, es, ed, esh);
            model(n, 1'b1, esd, edd, eshd);
            total += 2;
            if ({osym_h, ode_h, es_h, ek_h} !== {es, ed, esh, sticky_m}) begin
                bad++; $display("FAIL line_model n=%0d got=%h_%b%b%b exp=%h_%b%b%b",
                                n, osym_h, ode_h, es_h, ek_h, es, ed, esh, sticky_m);
            end
            if ({osym_d, ode_d, es_d, ek_d} !== {esd, edd, 2'b00}) begin
                bad++; $display("FAIL line_dvi n=%0d got=%h_%b%b%b exp=%h_%b00",
                                n, osym_d, ode_d, es_d, ek_d, esd, edd);
            end
            k = n - t;
            if (c >= 20 && k >= 1 && k <= 8) begin
                total += 2;
                if (osym_h[19:10] !== C01) begin
                    bad++; $display("FAIL line_preamble k=%0d got=%b exp=%b", k, osym_h[19:10], C01);
                end
                if (osym_d[19:10] !== C00 || ode_d !== 1'b0) begin
                    bad++; $display("FAIL line_dvi_ctrl k=%0d got=%b/%b exp=%b/0",
                                    k, osym_d[19:10], ode_d, C00);
                end
            end
            if (c >= 20 && (k == 9 || k == 10)) begin
                total++;
                if (osym_h !== {G2, G1, G0}) begin
                    bad++; $display("FAIL line_guard k=%0d got=%h exp=%h", k, osym_h, {G2, G1, G0});
                end
            end
            if (c >= 20 && k == 11) begin
                total += 2;
                if (osym_h !== sym_hist[t] || ode_h !== 1'b1) begin
                    bad++; $display("FAIL line_first_pixel got=%h/%b exp=%h/1", osym_h, ode_h,
                                    sym_hist[t]);
                end
                if (osym_d !== sym_hist[t] || ode_d !== 1'b1) begin
                    bad++; $display("FAIL line_dvi_first_pixel got=%h/%b exp=%h/1", osym_d, ode_d,
                                    sym_hist[t]);
                end
            end
        end
    endtask

    task automatic test_short_gap();
        logic [29:0] es; bit ed, esh;
        int r = 0;
        bit d;
        for (int c = 0; c < 40; c++) begin
            d = (c < 8) || (c >= 13 && c < 21);
            if (c == 13) r = n;
            drive(d, 1'b0, 1'b1, 30'($urandom), c == 36);
            model(n, 1'b0, es, ed, esh);
            total++;
            if ({osym_h, ode_h, es_h, ek_h} !== {es, ed, esh, sticky_m}) begin
                bad++; $display("FAIL short_model n=%0d got=%h_%b%b%b exp=%h_%b%b%b",
                                n, osym_h, ode_h, es_h, ek_h, es, ed, esh, sticky_m);
            end
            if (c >= 13 && n == r + 1) begin
                total++;
                if (es_h !== 1'b1 || ek_h !== 1'b1) begin
                    bad++; $display("FAIL short_pulse got=%b/%b exp=1/1", es_h, ek_h);
                end
            end
            if (c >= 13 && n == r + 2) begin
                total++;
                if (es_h !== 1'b0) begin
                    bad++; $display("FAIL short_pulse_width got=%b exp=0", es_h);
                end
            end
            if (c == 35 || c == 37) begin
                total++;
                if (ek_h !== (c == 35)) begin
                    bad++; $display("FAIL short_sticky c=%0d got=%b exp=%b", c, ek_h, c == 35);
                end
            end
        end
    endtask

    task automatic test_gap_boundary();
        logic [29:0] es; bit ed, esh;
        int b = 0;
        int q = 0;
        bit d;
        for (int c = 0; c < 81; c++) begin
            // line A at 20, gap 12, line B at 38, gap 11, line C at 55
            d = (c >= 20 && c < 26) || (c >= 38 && c < 44) || (c >= 55 && c < 61);
            if (c == 38) b = n;
            if (c == 55) q = n;
            drive(d, 1'b1, 1'b1, {10'($urandom), 10'h000, 10'($urandom)}, 1'b0);
            model(n, 1'b0, es, ed, esh);
            total++;
            if ({osym_h, ode_h, es_h, ek_h} !== {es, ed, esh, sticky_m}) begin
                bad++; $display("FAIL gap_model n=%0d got=%h_%b%b%b exp=%h_%b%b%b",
                                n, osym_h, ode_h, es_h, ek_h, es, ed, esh, sticky_m);
            end
            if (c >= 38 && n == b + 1) begin
                total++;
                if (osym_h[19:10] !== C01 || es_h !== 1'b0) begin
                    bad++; $display("FAIL gap12_accept got=%b/%b exp=%b/0", osym_h[19:10], es_h, C01);
                end
            end
            if (c >= 55 && n == q + 1) begin
                total++;
                if (es_h !== 1'b1) begin
                    bad++; $display("FAIL gap11_reject_pulse got=%b exp=1", es_h);
                end
            end
            if (c >= 55 && n >= q + 1 && n <= q + 8) begin
                total++;
                if (osym_h[19:10] === C01) begin
                    bad++; $display("FAIL gap11_no_preamble n=%0d got=%b exp=not %b",
                                    n, osym_h[19:10], C01);
                end
            end
        end
    endtask

    task automatic test_reset_mid_preamble();
        logic [29:0] es; bit ed, esh;
        int t = 0;
        for (int c = 0; c < 23; c++) drive(c >= 20, 1'b1, 1'b0, 30'($urandom), 1'b0);
        total++;
        if (osym_h[19:10] !== C01) begin
            bad++; $display("FAIL midrst_in_preamble got=%b exp=%b", osym_h[19:10], C01);
        end
        #1 rst_n = 1'b0;
        #1;
        total += 2;
        if ({osym_h, ode_h, es_h, ek_h} !== {C00, C00, C00, 3'b000}) begin
            bad++; $display("FAIL midrst_async got=%h_%b%b%b exp=%h_000", osym_h, ode_h, es_h, ek_h,
                            {C00, C00, C00});
        end
        if (clk_h !== ClkP) begin
            bad++; $display("FAIL midrst_clk got=%b exp=%b", clk_h, ClkP);
        end
        de = 1'b0;
        @(posedge clk);
        #1 release_reset();
        for (int c = 0; c < 45; c++) begin
            if (c == 15) t = n;
            drive(c >= 15 && c < 27, 1'b1, 1'b0, 30'($urandom), 1'b0);
            model(n, 1'b0, es, ed, esh);
            total++;
            if ({osym_h, ode_h, es_h, ek_h} !== {es, ed, esh, sticky_m}) begin
                bad++; $display("FAIL midrst_model n=%0d got=%h_%b%b%b exp=%h_%b%b%b",
                                n, osym_h, ode_h, es_h, ek_h, es, ed, esh, sticky_m);
            end
            if (c >= 15 && n == t + 11) begin
                total++;
                if (osym_h !== sym_hist[t] || ode_h !== 1'b1) begin
                    bad++; $display("FAIL midrst_first_pixel got=%h/%b exp=%h/1", osym_h, ode_h,
                                    sym_hist[t]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [29:0] es, esd; bit ed, esh, edd, eshd;
        int gap, len;
        rst_n = 1'b0;
        @(posedge clk);
        #1 release_reset();
        for (int line = 0; line < 60; line++) begin
            gap = $urandom_range(25, 1);
            len = $urandom_range(20, 1);
            for (int c = 0; c < gap + len; c++) begin
                drive(c >= gap, 1'($urandom), 1'($urandom), 30'($urandom),
                      ($urandom_range(15, 0) == 0));
                model(n, 1'b0, es, ed, esh);
                model(n, 1'b1, esd, edd, eshd);
                total += 2;
                if ({osym_h, ode_h, es_h, ek_h} !== {es, ed, esh, sticky_m}) begin
                    bad++; $display("FAIL rand_model n=%0d got=%h_%b%b%b exp=%h_%b%b%b",
                                    n, osym_h, ode_h, es_h, ek_h, es, ed, esh, sticky_m);
                end
                if ({osym_d, ode_d, es_d, ek_d} !== {esd, edd, 2'b00}) begin
                    bad++; $display("FAIL rand_dvi n=%0d got=%h_%b%b%b exp=%h_%b00",
                                    n, osym_d, ode_d, es_d, ek_d, esd, edd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_legal_line();
        test_short_gap();
        test_gap_boundary();
        test_reset_mid_preamble();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
